// File: rtl/serial_pkg.sv
// Shared constants and state type for the serial link (transmitter and receiver).
package serial_pkg;

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned DATA_BITS  = 8;
    localparam logic        START_BIT  = 1'b0;
    localparam logic        STOP_BIT   = 1'b1;

    // Encodings pinned so the state flop matches the legacy two-state layout.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } txState_t;

    function automatic logic [FRAME_BITS-1:0] makeFrame(input logic [DATA_BITS-1:0] data);
        return {STOP_BIT, data, START_BIT};
    endfunction

endpackage

// File: rtl/baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, pulses tick at terminal count.
module baud_counter #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == TERMINAL) ? '0 : count + 1'b1;
        end
    end

    assign tick = enable && (count == TERMINAL);

endmodule

// File: rtl/serial_transmitter.sv
// Parallel-to-serial framer: start bit, 8 data bits LSB-first, stop bit, each CLKS_PER_BIT cycles.
module serial_transmitter
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [DATA_BITS-1:0] TxData,
    input  logic                 TxValid,
    output logic                 TxReady,
    output logic                 SerialOUT,
    output logic                 Busy
);

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    txState_t              state;
    logic [3:0]            bitCnt;
    logic [FRAME_BITS-1:0] frame;
    logic                  shifting;
    logic                  bitTick;
    logic                  lastBitDone;
    logic                  transfer;

    assign shifting = (state == SHIFT);

    baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) baudCounter (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (transfer),
        .enable (shifting),
        .tick   (bitTick)
    );

    // Ready also in the last stop-bit cycle so back-to-back frames have no idle gap.
    assign lastBitDone = shifting && bitTick && (bitCnt == LAST_BIT);
    assign TxReady     = (state == IDLE) || lastBitDone;
    assign transfer    = TxValid && TxReady;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            bitCnt <= '0;
            frame  <= '1;
        end else if (transfer) begin
            state  <= SHIFT;
            bitCnt <= '0;
            frame  <= makeFrame(TxData);
        end else if (shifting && bitTick) begin
            frame <= {STOP_BIT, frame[FRAME_BITS-1:1]};
            if (lastBitDone) begin
                state  <= IDLE;
                bitCnt <= '0;
            end else begin
                bitCnt <= bitCnt + 1'b1;
            end
        end
    end

    // Frame fills with 1s while shifting, so bit 0 is the idle-high line outside a frame.
    assign SerialOUT = frame[0];
    assign Busy      = shifting;

endmodule
